// File: rtl/pix_stat_counter.sv
// Frame-level pixel statistics counter: per frame, counts beats passing a brightness
// test and total beats, latching both at end of frame with a one-cycle done pulse.
module pix_stat_counter #(
  parameter int CW    = 8,
  parameter int CNT_W = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clear,
  input  logic             i_pix_valid,
  input  logic             i_sof,
  input  logic             i_eof,
  input  logic [CW-1:0]    i_r,
  input  logic [CW-1:0]    i_g,
  input  logic [CW-1:0]    i_b,
  input  logic [1:0]       i_mode,
  input  logic [CW-1:0]    i_thr,
  output logic [CNT_W-1:0] o_live_cnt,
  output logic [CNT_W-1:0] o_lit_cnt,
  output logic [CNT_W-1:0] o_tot_cnt,
  output logic             o_sat,
  output logic             o_done,
  output logic             o_frame_err
);

  localparam int LW = CW + 8;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

  // Brightness test on the incoming beat, using the mode/threshold presented with it.
  logic [LW-1:0] w_lumaSum;
  logic [CW-1:0] w_luma;
  logic          w_rGt;
  logic          w_gGt;
  logic          w_bGt;
  logic          w_lumaGt;
  logic          w_hit;

  assign w_lumaSum = LW'(77) * LW'(i_r) + LW'(150) * LW'(i_g) + LW'(29) * LW'(i_b);
  assign w_luma    = w_lumaSum[LW-1:8];
  assign w_rGt     = i_r > i_thr;
  assign w_gGt     = i_g > i_thr;
  assign w_bGt     = i_b > i_thr;
  assign w_lumaGt  = w_luma > i_thr;

  always_comb begin
    w_hit = w_rGt & w_gGt & w_bGt;
    case (i_mode)
      2'd1:    w_hit = w_rGt | w_gGt | w_bGt;
      2'd2:    w_hit = w_lumaGt;
      default: w_hit = w_rGt & w_gGt & w_bGt;
    endcase
  end

  // Stage 1: frame markers are only kept when qualified by a valid beat.
  logic r_s1Valid;
  logic r_s1Sof;
  logic r_s1Eof;
  logic r_s1Hit;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1Valid <= 1'b0;
      r_s1Sof   <= 1'b0;
      r_s1Eof   <= 1'b0;
      r_s1Hit   <= 1'b0;
    end else if (i_clear) begin
      r_s1Valid <= 1'b0;
      r_s1Sof   <= 1'b0;
      r_s1Eof   <= 1'b0;
      r_s1Hit   <= 1'b0;
    end else begin
      r_s1Valid <= i_pix_valid;
      r_s1Sof   <= i_pix_valid & i_sof;
      r_s1Eof   <= i_pix_valid & i_eof;
      r_s1Hit   <= i_pix_valid & w_hit;
    end
  end

  // Stage 2 state and counters.
  state_t           r_state;
  state_t           w_stateNxt;
  logic [CNT_W-1:0] r_liveCnt;
  logic [CNT_W-1:0] r_totCnt;
  logic             r_satFlag;
  logic [CNT_W-1:0] r_litLatched;
  logic [CNT_W-1:0] r_totLatched;
  logic             r_satLatched;
  logic             r_done;
  logic             r_frameErr;

  logic [CNT_W-1:0] w_liveNxt;
  logic [CNT_W-1:0] w_totNxt;
  logic             w_satFlagNxt;
  logic             w_latch;
  logic             w_errSet;
  logic             w_totOvf;
  logic             w_liveOvf;
  logic [CNT_W-1:0] w_totInc;
  logic [CNT_W-1:0] w_liveInc;

  // Saturating increments: an increment attempted at full scale is what marks saturation.
  assign w_totOvf  = (r_totCnt == CNT_MAX);
  assign w_liveOvf = r_s1Hit & (r_liveCnt == CNT_MAX);
  assign w_totInc  = w_totOvf ? r_totCnt : r_totCnt + CNT_ONE;
  assign w_liveInc = (r_s1Hit && !w_liveOvf) ? r_liveCnt + CNT_ONE : r_liveCnt;

  always_comb begin
    w_stateNxt   = r_state;
    w_liveNxt    = r_liveCnt;
    w_totNxt     = r_totCnt;
    w_satFlagNxt = r_satFlag;
    w_latch      = 1'b0;
    w_errSet     = 1'b0;
    if (r_s1Valid) begin
      if (r_s1Sof) begin
        w_errSet     = (r_state == ST_ACTIVE) && !r_s1Eof;
        w_liveNxt    = {{(CNT_W-1){1'b0}}, r_s1Hit};
        w_totNxt     = CNT_ONE;
        w_satFlagNxt = 1'b0;
        if (r_s1Eof) begin
          w_latch    = 1'b1;
          w_stateNxt = ST_IDLE;
        end else begin
          w_stateNxt = ST_ACTIVE;
        end
      end else if (r_state == ST_ACTIVE) begin
        w_liveNxt    = w_liveInc;
        w_totNxt     = w_totInc;
        w_satFlagNxt = r_satFlag | w_totOvf | w_liveOvf;
        if (r_s1Eof) begin
          w_latch    = 1'b1;
          w_stateNxt = ST_IDLE;
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else if (i_clear) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_stateNxt;
    end
  end

  // Results latch the same values the counters take on the eof beat, so the eof pixel counts.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_liveCnt    <= '0;
      r_totCnt     <= '0;
      r_satFlag    <= 1'b0;
      r_litLatched <= '0;
      r_totLatched <= '0;
      r_satLatched <= 1'b0;
      r_done       <= 1'b0;
      r_frameErr   <= 1'b0;
    end else if (i_clear) begin
      r_liveCnt    <= '0;
      r_totCnt     <= '0;
      r_satFlag    <= 1'b0;
      r_litLatched <= '0;
      r_totLatched <= '0;
      r_satLatched <= 1'b0;
      r_done       <= 1'b0;
      r_frameErr   <= 1'b0;
    end else begin
      r_liveCnt <= w_liveNxt;
      r_totCnt  <= w_totNxt;
      r_satFlag <= w_satFlagNxt;
      r_done    <= w_latch;
      if (w_latch) begin
        r_litLatched <= w_liveNxt;
        r_totLatched <= w_totNxt;
        r_satLatched <= w_satFlagNxt;
      end
      if (w_errSet) begin
        r_frameErr <= 1'b1;
      end
    end
  end

  assign o_live_cnt  = r_liveCnt;
  assign o_lit_cnt   = r_litLatched;
  assign o_tot_cnt   = r_totLatched;
  assign o_sat       = r_satLatched;
  assign o_done      = r_done;
  assign o_frame_err = r_frameErr;

endmodule
